dcache_meta_array: RTL
======================

Name: dcache_meta_array

Overview:
Multi-way metadata array (tags, valid/dirty bits, LRU state) for the data cache, holding one WIDTH-bit entry per way per set.
- One registered read port returns all ways of a set at once; per-way bypass forwards a same-cycle write to the read.
- One write port with a per-way write mask.
- A built-in clear sequencer walks every set, one per cycle, and writes RESET_VAL. This replaces a single-cycle array reset, which is too wide at this size; the sequencer runs on reset and on software/flush request.

Parameters:
- S_INDEX, 5: set index width; NUM_SETS = 2**S_INDEX.
- WIDTH, 24: bits per way entry.
- WAYS, 4: number of ways, >= 1.
- RESET_VAL, 0: WIDTH-bit value written to every entry by the clear sequencer.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- clear_req  in  1  start a full-array clear walk; single-cycle pulse or level.
- busy  out  1  clear walk in progress; reads and writes are ignored while high.
- read  in  1  read enable.
- rindex  in  S_INDEX  read set index.
- dataout  out  WAYS*WIDTH  registered read data; way w is in bits [w*WIDTH +: WIDTH].
- load_mask  in  WAYS  per-way write enable.
- windex  in  S_INDEX  write set index.
- datain  in  WAYS*WIDTH  write data, packed the same way as dataout.

Behaviour:
- FSM states: IDLE, CLEAR. A counter clr_idx of width S_INDEX selects the set being cleared.
- rst=1 at a clock edge:
  - state <= CLEAR, clr_idx <= 0, busy <= 1, dataout <= 0.
  - Array contents are not touched by rst directly; the walk clears them.
  - rst asserted mid-walk restarts the walk at set 0.
- CLEAR, every cycle:
  - all ways of set clr_idx <= RESET_VAL; clr_idx <= clr_idx+1.
  - When clr_idx == NUM_SETS-1: state <= IDLE, busy <= 0 on that same edge, clr_idx wraps to 0.
  - A walk takes exactly NUM_SETS cycles; busy is high for NUM_SETS consecutive cycles.
- While busy=1:
  - read is ignored and dataout holds its value.
  - load_mask is ignored; no user write occurs.
  - clear_req is ignored; the walk does not restart.
- IDLE with clear_req=1: state <= CLEAR, clr_idx <= 0, busy=1 from the next cycle. Any load or read in that same cycle still executes normally.
- Read (IDLE, read=1): dataout updates at the next edge, 1-cycle latency. For each way w independently:
  - if load_mask[w]=1 and rindex==windex, dataout way w <= datain way w (bypass);
  - otherwise dataout way w <= stored[rindex][w], the value before this edge's write.
- read=0: dataout holds.
- Write (IDLE): for each w with load_mask[w]=1, stored[windex][w] <= datain way w. Ways with mask 0 are unchanged.
- Simultaneous read and write:
  - different index: read returns old data.
  - same index: masked ways return new data; unmasked ways return stored data.
- Indices are unsigned with no range error; every value addresses a valid set.
- WAYS=1 degenerates to a single-way array with bypass plus a clear walk.

Test Plan:
1. Reset with defaults: rst high 1 cycle -> busy=1 for exactly 32 cycles, then 0; dataout=0. A read of set 7 ways 0-3 then returns 0 for every way.
2. Masked write then read: datain = {w3=0xAAAAAA, w2=0xBBBBBB, w1=0xCCCCCC, w0=0xDDDDDD}, load_mask=4'b0101, windex=3. Next cycle read rindex=3 -> dataout = {0, 0xBBBBBB, 0, 0xDDDDDD}.
3. Bypass: set 5 holds 0x111111 in all ways. Same cycle: read rindex=5, load_mask=4'b0010, windex=5, datain w1=0x222222 -> dataout w1=0x222222, other ways 0x111111. Next read of set 5 -> w1=0x222222.
4. No bypass on index mismatch: read rindex=4 with write windex=5 in the same cycle -> dataout shows the old set-4 data. Holds: read=0 for 3 cycles -> dataout unchanged.
5. Clear request mid-traffic:
   - Sets 0-31 filled with nonzero data; pulse clear_req with a write to set 9 in the same cycle -> the write lands, then busy=1 for 32 cycles.
   - During the walk, read and load are ignored (dataout frozen) and a second clear_req has no effect.
   - After the walk, all sets read RESET_VAL.
6. Reset mid-walk: assert rst at walk cycle 10 -> walk restarts, busy stays high 32 more cycles; all entries equal RESET_VAL afterwards. Repeat with RESET_VAL=0xFFFFFF, WAYS=2, S_INDEX=3 -> busy for 8 cycles.

Source files
------------

// File: rtl/dcache_meta_array.sv
// Data-cache metadata array: WAYS entries of WIDTH bits per set.
// It has one registered read port that returns every way of a set.
// A same-cycle write to the read set is forwarded per way.
// It has one write port with a per-way mask.
// A clear sequencer writes RESET_VAL to one set per cycle, walking all sets.
// The walk runs after reset and on clear_req.
module dcache_meta_array #(
    parameter int               S_INDEX   = 5,
    parameter int               WIDTH     = 24,
    parameter int               WAYS      = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_req,
    output logic                    busy,
    input  logic                    read,
    input  logic [S_INDEX-1:0]      rindex,
    output logic [WAYS*WIDTH-1:0]   dataout,
    input  logic [WAYS-1:0]         load_mask,
    input  logic [S_INDEX-1:0]      windex,
    input  logic [WAYS*WIDTH-1:0]   datain
);

    localparam int NUM_SETS = 2 ** S_INDEX;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state_reg;
    logic [S_INDEX-1:0]  clr_idx_reg;
    logic                busy_reg;

    // User reads are accepted only while no clear walk is running.
    logic                rd_en;
    logic                same_index;

    assign busy       = busy_reg;
    assign rd_en      = read && !busy_reg;
    assign same_index = (rindex == windex);

    // Clear-walk sequencer.
    // busy is registered and drops on the same edge that writes the last set.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= CLEAR;
            clr_idx_reg <= '0;
            busy_reg    <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (clear_req) begin
                        state_reg   <= CLEAR;
                        clr_idx_reg <= '0;
                        busy_reg    <= 1'b1;
                    end
                end
                CLEAR: begin
                    clr_idx_reg <= clr_idx_reg + 1'b1;
                    if (&clr_idx_reg) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Each way has its own storage array with a single write port.
    // The clear walk owns that port while busy.
    // rst blocks writes so that reset alone never alters stored contents.
    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            logic [WIDTH-1:0]   mem [NUM_SETS];
            logic               we;
            logic [S_INDEX-1:0] waddr;
            logic [WIDTH-1:0]   wdata;
            logic [WIDTH-1:0]   way_in;
            logic [WIDTH-1:0]   dout_reg;

            assign way_in = datain[gi*WIDTH +: WIDTH];
            assign we     = !rst && (busy_reg || load_mask[gi]);
            assign waddr  = busy_reg ? clr_idx_reg : windex;
            assign wdata  = busy_reg ? RESET_VAL : way_in;

            // Storage write: clear walk data or masked user data.
            always_ff @(posedge clk) begin
                if (we) begin
                    mem[waddr] <= wdata;
                end
            end

            // Registered read with per-way forwarding of a same-set write.
            // The array read sees pre-write contents, because the write is non-blocking.
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_reg <= '0;
                end else if (rd_en) begin
                    if (load_mask[gi] && same_index) begin
                        dout_reg <= way_in;
                    end else begin
                        dout_reg <= mem[rindex];
                    end
                end
            end

            assign dataout[gi*WIDTH +: WIDTH] = dout_reg;
        end
    endgenerate

endmodule
